// File: rtl/multi_pkg.sv
// Shared constants and types for the 78x78 limb-product recombiner.
package multi_pkg;

    // Operand and limb geometry
    localparam int RADIX  = 78;
    localparam int A_W    = 26;
    localparam int B_W    = 17;
    localparam int PP_W   = 43;
    localparam int N_A    = 3;
    localparam int N_B    = 5;
    localparam int N_PP   = N_A * N_B;
    localparam int PROD_W = 2 * RADIX;

    // One a-limb row spans the full b operand plus one a-limb of shift headroom
    localparam int ROW_W  = A_W + RADIX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Position of the least significant bit of partial product res_(i+5j)
    function automatic int pp_offset(input int j, input int i);
        return A_W * j + B_W * i;
    endfunction

endpackage

// File: rtl/multi_rowsum.sv
// Combinational adder for one a-limb row: sums the five b-column partial
// products, each shifted by its column weight, into a zero-extended row sum.
module multi_rowsum
    import multi_pkg::*;
#(
    parameter int PP_W_P  = multi_pkg::PP_W,
    parameter int B_W_P   = multi_pkg::B_W,
    parameter int N_B_P   = multi_pkg::N_B,
    parameter int ROW_W_P = multi_pkg::ROW_W
) (
    input  logic [N_B_P-1:0][PP_W_P-1:0] i_pp,
    output logic [ROW_W_P-1:0]           o_rowsum
);

    logic [ROW_W_P-1:0] w_sum;

    // Shift each column product by B_W*i and accumulate; the top column is
    // narrow for legal operands, so truncation to ROW_W never loses bits.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N_B_P; i++) begin
            w_sum = w_sum + (ROW_W_P'(i_pp[i]) << (B_W_P * i));
        end
    end

    assign o_rowsum = w_sum;

endmodule

// File: rtl/multi_recombine.sv
// Sequential recombiner: accepts 15 limb partial products in one handshake,
// folds in one a-limb row per cycle, and presents the 156-bit product under
// an output valid/ready handshake.
module multi_recombine
    import multi_pkg::*;
#(
    parameter int RADIX = multi_pkg::RADIX,
    parameter int A_W   = multi_pkg::A_W,
    parameter int B_W   = multi_pkg::B_W,
    parameter int PP_W  = multi_pkg::PP_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PP_W-1:0]      res_0,
    input  logic [PP_W-1:0]      res_1,
    input  logic [PP_W-1:0]      res_2,
    input  logic [PP_W-1:0]      res_3,
    input  logic [PP_W-1:0]      res_4,
    input  logic [PP_W-1:0]      res_5,
    input  logic [PP_W-1:0]      res_6,
    input  logic [PP_W-1:0]      res_7,
    input  logic [PP_W-1:0]      res_8,
    input  logic [PP_W-1:0]      res_9,
    input  logic [PP_W-1:0]      res_10,
    input  logic [PP_W-1:0]      res_11,
    input  logic [PP_W-1:0]      res_12,
    input  logic [PP_W-1:0]      res_13,
    input  logic [PP_W-1:0]      res_14,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*RADIX-1:0]   product
);

    localparam int PRD_W = 2 * RADIX;
    localparam int RSW   = A_W + RADIX;
    localparam logic [1:0] LAST_ROW = 2'(N_A - 1);

    // Control state
    state_t               r_state;
    logic [1:0]           r_row;
    logic                 r_in_ready;
    logic                 r_out_valid;

    // Captured operands, running sum and held result
    logic [PP_W-1:0]      r_pp [N_PP];
    logic [PRD_W-1:0]     r_acc;
    logic [PRD_W-1:0]     r_product;

    logic [PP_W-1:0]      w_res [N_PP];
    logic [N_B-1:0][PP_W-1:0] w_sel;
    logic [RSW-1:0]       w_rowsum;
    logic [PRD_W-1:0]     w_row_shifted;
    logic [PRD_W-1:0]     w_acc_next;

    assign w_res[0]  = res_0;
    assign w_res[1]  = res_1;
    assign w_res[2]  = res_2;
    assign w_res[3]  = res_3;
    assign w_res[4]  = res_4;
    assign w_res[5]  = res_5;
    assign w_res[6]  = res_6;
    assign w_res[7]  = res_7;
    assign w_res[8]  = res_8;
    assign w_res[9]  = res_9;
    assign w_res[10] = res_10;
    assign w_res[11] = res_11;
    assign w_res[12] = res_12;
    assign w_res[13] = res_13;
    assign w_res[14] = res_14;

    // Select the five captured products belonging to the current a-limb row
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_B; i++) begin
            case (r_row)
                2'd0:    w_sel[i] = r_pp[i];
                2'd1:    w_sel[i] = r_pp[i + N_B];
                default: w_sel[i] = r_pp[i + 2 * N_B];
            endcase
        end
    end

    multi_rowsum #(
        .PP_W_P  (PP_W),
        .B_W_P   (B_W),
        .N_B_P   (N_B),
        .ROW_W_P (RSW)
    ) u_rowsum (
        .i_pp     (w_sel),
        .o_rowsum (w_rowsum)
    );

    // Place the row sum at its a-limb weight; the sum wraps mod 2^PRD_W
    always_comb begin
        w_row_shifted = '0;
        case (r_row)
            2'd0:    w_row_shifted = PRD_W'(w_rowsum);
            2'd1:    w_row_shifted = PRD_W'(w_rowsum) << A_W;
            default: w_row_shifted = PRD_W'(w_rowsum) << (2 * A_W);
        endcase
    end

    assign w_acc_next = r_acc + w_row_shifted;

    // Control FSM with registered handshake outputs; the result register is
    // loaded only on the cycle that completes the last row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_product   <= '0;
            for (int k = 0; k < N_PP; k++) begin
                r_pp[k] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < N_PP; k++) begin
                            r_pp[k] <= w_res[k];
                        end
                        r_acc      <= '0;
                        r_row      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ACC;
                    end
                end
                ACC: begin
                    r_acc <= w_acc_next;
                    r_row <= r_row + 2'd1;
                    if (r_row == LAST_ROW) begin
                        r_product   <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;

endmodule

// File: tb/tb_multi_recombine.sv
// Directed bench for multi_recombine: reset, handshake timing, arithmetic
// corner vectors, backpressure and mid-operation reset.
module tb_multi_recombine;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [42:0]   res [15];
    logic          out_valid;
    logic          out_ready;
    logic [155:0]  product;

    int n_tests;
    int n_fail;

    multi_recombine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_0     (res[0]),
        .res_1     (res[1]),
        .res_2     (res[2]),
        .res_3     (res[3]),
        .res_4     (res[4]),
        .res_5     (res[5]),
        .res_6     (res[6]),
        .res_7     (res[7]),
        .res_8     (res[8]),
        .res_9     (res[9]),
        .res_10    (res[10]),
        .res_11    (res[11]),
        .res_12    (res[12]),
        .res_13    (res[13]),
        .res_14    (res[14]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [155:0] got, input logic [155:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_res();
        for (int k = 0; k < 15; k++) res[k] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise in_valid, wait (bounded) for in_ready, and step past the accept edge
    task automatic accept_set(input string tag, input bit keep_valid);
        int guard;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 40) begin
            step();
            guard++;
        end
        check({tag, "_ready_seen"}, 156'(in_ready), 156'(1));
        step();
        if (!keep_valid) in_valid = 1'b0;
        check({tag, "_busy"}, 156'(in_ready), 156'(0));
    endtask

    // After the accept edge: no valid for two edges, valid and result on the third
    task automatic expect_result(input string tag, input logic [155:0] exp);
        step();
        check({tag, "_nv1"}, 156'(out_valid), 156'(0));
        step();
        check({tag, "_nv2"}, 156'(out_valid), 156'(0));
        step();
        check({tag, "_valid"}, 156'(out_valid), 156'(1));
        check({tag, "_prod"}, product, exp);
    endtask

    // Full transaction with out_ready high; checks the return to IDLE
    task automatic run_txn(input string tag, input logic [155:0] exp);
        out_ready = 1'b1;
        accept_set(tag, 1'b0);
        expect_result(tag, exp);
        step();
        check({tag, "_vdrop"}, 156'(out_valid), 156'(0));
        check({tag, "_idle"}, 156'(in_ready), 156'(1));
        check({tag, "_hold"}, product, exp);
    endtask

    longint       a26, b17, b10;
    logic [155:0] exp_max;
    logic [155:0] exp_mix;
    logic [155:0] exp_b4;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        clr_res();
        res[0] = 43'd1;

        // Reset held for three cycles while upstream offers a set
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_in_ready", 156'(in_ready), 156'(1));
            check("rst_out_valid", 156'(out_valid), 156'(0));
            check("rst_product", product, 156'(0));
        end
        rst_n = 1'b1;

        // a=1, b=1
        run_txn("one", 156'(1));

        // a=b=2^78-1
        a26 = (longint'(1) << 26) - 1;
        b17 = (longint'(1) << 17) - 1;
        b10 = (longint'(1) << 10) - 1;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 5; i++) begin
                res[i + 5 * j] = (i < 4) ? 43'(a26 * b17) : 43'(a26 * b10);
            end
        end
        exp_max = '1;
        exp_max = exp_max - (156'(1) << 79) + 156'(2);
        run_txn("max", exp_max);

        // Mixed row/column weights: res_0=1, res_6=1 (bit 43), res_13=3 (bit 103)
        clr_res();
        res[0]  = 43'd1;
        res[6]  = 43'd1;
        res[13] = 43'd3;
        exp_mix = 156'(1) + (156'(1) << 43) + (156'(3) << 103);
        run_txn("mix", exp_mix);

        // Row 1, top column: res_9 = 5 sits at 26 + 68 = 94
        clr_res();
        res[9] = 43'd5;
        exp_b4 = 156'(5) << 94;
        run_txn("r1c4", exp_b4);

        // Single cross term res_14 -> 2^120, then backpressure with a pending set
        clr_res();
        res[14] = 43'd1;
        out_ready = 1'b0;
        accept_set("bp", 1'b1);
        clr_res();
        res[0] = 43'd15;
        expect_result("bp", 156'(1) << 120);
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp_stable", product, 156'(1) << 120);
            check("bp_valid_held", 156'(out_valid), 156'(1));
            check("bp_in_ready", 156'(in_ready), 156'(0));
        end
        out_ready = 1'b1;
        step();
        check("bp_release_valid", 156'(out_valid), 156'(0));
        check("bp_release_ready", 156'(in_ready), 156'(1));
        check("bp_release_prod", product, 156'(1) << 120);
        step();
        check("bp2_accepted", 156'(in_ready), 156'(0));
        in_valid = 1'b0;
        expect_result("bp2", 156'(15));
        step();
        check("bp2_vdrop", 156'(out_valid), 156'(0));

        // Mid-operation reset two edges after acceptance
        clr_res();
        res[14] = 43'd1;
        accept_set("mrst", 1'b0);
        step();
        rst_n = 1'b0;
        step();
        check("mrst_in_ready", 156'(in_ready), 156'(1));
        check("mrst_out_valid", 156'(out_valid), 156'(0));
        check("mrst_product", product, 156'(0));
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("mrst_no_valid", 156'(out_valid), 156'(0));
            check("mrst_prod_zero", product, 156'(0));
        end

        // a=3, b=5 after the aborted operation
        clr_res();
        res[0] = 43'd15;
        run_txn("post", 156'(15));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
